// File: rtl/udma_filter_pkg.sv
// Shared types and helpers for the uDMA filter data-out engine.
package udma_filter_pkg;

   localparam int unsigned INC_W = 3;

   typedef enum logic [1:0] {
      MODE_LINEAR   = 2'd0,
      MODE_SLIDING  = 2'd1,
      MODE_CIRCULAR = 2'd2,
      MODE_2D       = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_RUNNING = 1'b1
   } state_e;

   // Byte increment per beat for a given element size code.
   function automatic logic [INC_W-1:0] datasize_to_inc(input logic [1:0] ds);
      case (ds)
         2'b00:   return INC_W'(1);
         2'b01:   return INC_W'(2);
         default: return INC_W'(4);
      endcase
   endfunction

endpackage

// File: rtl/io_generic_fifo.sv
// Register-based FIFO with synchronous flush; read data comes straight from the head entry.
module io_generic_fifo #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned BUFFER_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  clr_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i
);

   localparam int unsigned PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
   logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  push, pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(BUFFER_DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   assign ready_o = (cnt_q != CNT_W'(BUFFER_DEPTH));
   assign valid_o = (cnt_q != '0);
   assign data_o  = mem_q[rd_q];
   assign push    = valid_i & ready_o & ~clr_i;
   assign pop     = valid_o & ready_i & ~clr_i;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (clr_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) wr_d = ptr_next(wr_q);
         if (pop)  rd_d = ptr_next(rd_q);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < int'(BUFFER_DEPTH); i++) mem_q[i] <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         if (push) mem_q[wr_q] <= data_i;
      end
   end

endmodule

// File: rtl/udma_filter_rx_dataout_2d.sv
// Output DMA engine: drains the filter stream into the uDMA RX channel with
// linear, sliding-window, circular and 2D-strided L2 address generation.
module udma_filter_rx_dataout_2d
   import udma_filter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned L2_AWIDTH_NOAL = 15,
   parameter int unsigned BUFFER_DEPTH   = 4,
   parameter int unsigned TRANS_SIZE     = 16
) (
   input  logic                      clk_i,
   input  logic                      resetn_i,

   output logic [L2_AWIDTH_NOAL-1:0] rx_ch_addr_o,
   output logic [1:0]                rx_ch_datasize_o,
   output logic                      rx_ch_valid_o,
   output logic [DATA_WIDTH-1:0]     rx_ch_data_o,
   input  logic                      rx_ch_ready_i,

   input  logic                      cmd_start_i,
   input  logic                      cmd_clr_i,
   output logic                      cmd_done_o,
   output logic                      busy_o,

   input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
   input  logic [1:0]                cfg_datasize_i,
   input  logic [1:0]                cfg_mode_i,
   input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
   input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
   input  logic [L2_AWIDTH_NOAL-1:0] cfg_stride_i,

   input  logic [DATA_WIDTH-1:0]     stream_data_i,
   input  logic                      stream_valid_i,
   output logic                      stream_ready_o
);

   localparam int unsigned AW = L2_AWIDTH_NOAL;

   state_e                state_q, state_d;
   mode_e                 mode_q, mode_d;
   logic [1:0]            ds_q, ds_d;
   logic [TRANS_SIZE-1:0] len0_q, len0_d, len1_q, len1_d;
   logic [TRANS_SIZE-1:0] w_q, w_d, l_q, l_d;
   logic [AW-1:0]         stride_q, stride_d;
   logic [AW-1:0]         row_base_q, row_base_d;
   logic [AW-1:0]         ptr_q, ptr_d;
   logic                  done_q, done_d;

   logic                  running, fifo_valid, fifo_pop, accept, row_end, last_beat;
   logic [AW-1:0]         inc;

   assign running   = (state_q == ST_RUNNING);
   assign inc       = AW'(datasize_to_inc(ds_q));
   assign fifo_pop  = rx_ch_ready_i & running;
   assign accept    = rx_ch_valid_o & rx_ch_ready_i;
   assign row_end   = (w_q == len0_q);
   assign last_beat = row_end & ((mode_q == MODE_LINEAR) | (l_q == len1_q));

   assign rx_ch_valid_o    = fifo_valid & running;
   assign rx_ch_addr_o     = ptr_q;
   assign rx_ch_datasize_o = ds_q;
   assign cmd_done_o       = done_q;
   assign busy_o           = running;

   io_generic_fifo #(
      .DATA_WIDTH   (DATA_WIDTH),
      .BUFFER_DEPTH (BUFFER_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rstn_i  (resetn_i),
      .clr_i   (cmd_clr_i),
      .data_i  (stream_data_i),
      .valid_i (stream_valid_i),
      .ready_o (stream_ready_o),
      .data_o  (rx_ch_data_o),
      .valid_o (fifo_valid),
      .ready_i (fifo_pop)
   );

   // Next-state: command latch, beat counters and per-mode pointer update.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      ds_d       = ds_q;
      len0_d     = len0_q;
      len1_d     = len1_q;
      stride_d   = stride_q;
      row_base_d = row_base_q;
      ptr_d      = ptr_q;
      w_d        = w_q;
      l_d        = l_q;
      done_d     = 1'b0;

      if (cmd_clr_i) begin
         state_d = ST_IDLE;
         w_d     = '0;
         l_d     = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_start_i) begin
                  state_d    = ST_RUNNING;
                  mode_d     = mode_e'(cfg_mode_i);
                  ds_d       = cfg_datasize_i;
                  len0_d     = cfg_len0_i;
                  len1_d     = cfg_len1_i;
                  stride_d   = cfg_stride_i;
                  row_base_d = cfg_start_addr_i;
                  ptr_d      = cfg_start_addr_i;
                  w_d        = '0;
                  l_d        = '0;
               end
            end
            ST_RUNNING: begin
               if (accept) begin
                  if (row_end) begin
                     w_d = '0;
                     l_d = l_q + TRANS_SIZE'(1);
                  end else begin
                     w_d = w_q + TRANS_SIZE'(1);
                  end

                  if (!row_end || (mode_q == MODE_LINEAR)) begin
                     ptr_d = ptr_q + inc;
                  end else begin
                     // Row boundary: the next row/window start depends on the mode.
                     case (mode_q)
                        MODE_SLIDING: begin
                           row_base_d = row_base_q + inc;
                           ptr_d      = row_base_q + inc;
                        end
                        MODE_CIRCULAR: ptr_d = row_base_q;
                        default: begin
                           row_base_d = row_base_q + stride_q;
                           ptr_d      = row_base_q + stride_q;
                        end
                     endcase
                  end

                  if (last_beat) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_LINEAR;
         ds_q       <= '0;
         len0_q     <= '0;
         len1_q     <= '0;
         stride_q   <= '0;
         row_base_q <= '0;
         ptr_q      <= '0;
         w_q        <= '0;
         l_q        <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         ds_q       <= ds_d;
         len0_q     <= len0_d;
         len1_q     <= len1_d;
         stride_q   <= stride_d;
         row_base_q <= row_base_d;
         ptr_q      <= ptr_d;
         w_q        <= w_d;
         l_q        <= l_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_udma_filter_rx_dataout_2d.sv
// Directed scoreboard bench for udma_filter_rx_dataout_2d: address patterns,
// backpressure, abort, done pulse and asynchronous reset.
module tb_udma_filter_rx_dataout_2d;
   import udma_filter_pkg::*;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 15;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TS    = 16;

   logic          clk_i = 1'b0;
   logic          resetn_i;
   logic [AW-1:0] rx_ch_addr_o;
   logic [1:0]    rx_ch_datasize_o;
   logic          rx_ch_valid_o;
   logic [DW-1:0] rx_ch_data_o;
   logic          rx_ch_ready_i;
   logic          cmd_start_i, cmd_clr_i, cmd_done_o, busy_o;
   logic [AW-1:0] cfg_start_addr_i, cfg_stride_i;
   logic [1:0]    cfg_datasize_i, cfg_mode_i;
   logic [TS-1:0] cfg_len0_i, cfg_len1_i;
   logic [DW-1:0] stream_data_i;
   logic          stream_valid_i, stream_ready_o;

   udma_filter_rx_dataout_2d #(
      .DATA_WIDTH(DW), .L2_AWIDTH_NOAL(AW), .BUFFER_DEPTH(DEPTH), .TRANS_SIZE(TS)
   ) dut (
      .clk_i(clk_i), .resetn_i(resetn_i),
      .rx_ch_addr_o(rx_ch_addr_o), .rx_ch_datasize_o(rx_ch_datasize_o),
      .rx_ch_valid_o(rx_ch_valid_o), .rx_ch_data_o(rx_ch_data_o), .rx_ch_ready_i(rx_ch_ready_i),
      .cmd_start_i(cmd_start_i), .cmd_clr_i(cmd_clr_i), .cmd_done_o(cmd_done_o), .busy_o(busy_o),
      .cfg_start_addr_i(cfg_start_addr_i), .cfg_datasize_i(cfg_datasize_i), .cfg_mode_i(cfg_mode_i),
      .cfg_len0_i(cfg_len0_i), .cfg_len1_i(cfg_len1_i), .cfg_stride_i(cfg_stride_i),
      .stream_data_i(stream_data_i), .stream_valid_i(stream_valid_i), .stream_ready_o(stream_ready_o)
   );

   always #5 clk_i = ~clk_i;

   int            total = 0;
   int            bad = 0;
   logic [AW-1:0] exp_addr_q[$];
   logic [DW-1:0] exp_data_q[$];
   logic [DW-1:0] stim_q[$];
   int            fifo_cnt = 0;
   int            accepts = 0;
   logic          busy_exp = 1'b0;
   logic          done_exp = 1'b0;
   logic          stall_prev = 1'b0;
   logic          rand_rdy = 1'b0;
   logic [AW-1:0] held_addr = '0;
   logic [DW-1:0] held_data = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference address list for one transfer, built row by row.
   task automatic expect_xfer(input logic [AW-1:0] start, input logic [1:0] ds, input logic [1:0] mode,
                              input int len0, input int len1, input logic [AW-1:0] stride);
      logic [AW-1:0] inc, base;
      int rows;
      inc  = (ds == 2'd0) ? AW'(1) : (ds == 2'd1) ? AW'(2) : AW'(4);
      rows = (mode == 2'd0) ? 1 : len1 + 1;
      for (int r = 0; r < rows; r++) begin
         case (mode)
            2'd1:    base = start + AW'(r) * inc;
            2'd3:    base = start + AW'(r) * stride;
            default: base = start;
         endcase
         for (int e = 0; e <= len0; e++) exp_addr_q.push_back(base + AW'(e) * inc);
      end
   endtask

   task automatic push_words(input int n);
      logic [DW-1:0] w;
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         stim_q.push_back(w);
         exp_data_q.push_back(w);
      end
   endtask

   // One clock: drive, sample at negedge+1, update models, advance to next negedge.
   task automatic tick();
      logic acc, push;
      if (rand_rdy) rx_ch_ready_i = 1'($urandom_range(0, 1));
      stream_valid_i = (stim_q.size() != 0);
      stream_data_i  = (stim_q.size() != 0) ? stim_q[0] : '0;
      #1;
      chk("busy", busy_o, busy_exp);
      chk("done", cmd_done_o, done_exp);
      chk("stream_ready", stream_ready_o, fifo_cnt != int'(DEPTH));
      chk("valid", rx_ch_valid_o, busy_exp && (fifo_cnt != 0));
      if (stall_prev) begin
         chk("hold_addr", rx_ch_addr_o, held_addr);
         chk("hold_data", rx_ch_data_o, held_data);
      end
      acc      = rx_ch_valid_o && rx_ch_ready_i && !cmd_clr_i;
      push     = stream_valid_i && stream_ready_o;
      done_exp = 1'b0;
      if (acc) begin
         accepts++;
         if (exp_addr_q.size() == 0 || exp_data_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL beat_unexpected observed addr=%0h expected no beat", rx_ch_addr_o);
         end else begin
            chk("beat_addr", rx_ch_addr_o, exp_addr_q.pop_front());
            chk("beat_data", rx_ch_data_o, exp_data_q.pop_front());
            if (exp_addr_q.size() == 0) done_exp = 1'b1;
         end
      end
      stall_prev = rx_ch_valid_o && !rx_ch_ready_i && !cmd_clr_i;
      held_addr  = rx_ch_addr_o;
      held_data  = rx_ch_data_o;
      if (cmd_clr_i) begin
         fifo_cnt = 0;
         busy_exp = 1'b0;
      end else begin
         fifo_cnt = fifo_cnt + int'(push) - int'(acc);
         if (done_exp) busy_exp = 1'b0;
         else if (cmd_start_i && !busy_exp) busy_exp = 1'b1;
         if (push) void'(stim_q.pop_front());
      end
      @(negedge clk_i);
   endtask

   task automatic start_xfer(input logic [AW-1:0] start, input logic [1:0] ds, input logic [1:0] mode,
                             input int len0, input int len1, input logic [AW-1:0] stride);
      cfg_start_addr_i = start;
      cfg_datasize_i   = ds;
      cfg_mode_i       = mode;
      cfg_len0_i       = TS'(len0);
      cfg_len1_i       = TS'(len1);
      cfg_stride_i     = stride;
      cmd_start_i      = 1'b1;
      expect_xfer(start, ds, mode, len0, len1, stride);
      tick();
      cmd_start_i      = 1'b0;
      // Scramble the config: the running transfer must ignore it.
      cfg_start_addr_i = AW'($urandom);
      cfg_datasize_i   = 2'($urandom);
      cfg_mode_i       = 2'($urandom);
      cfg_len0_i       = TS'($urandom);
      cfg_len1_i       = TS'($urandom);
      cfg_stride_i     = AW'($urandom);
      chk("start_busy", busy_o, 1'b1);
      chk("start_addr", rx_ch_addr_o, start);
      chk("start_ds", rx_ch_datasize_o, ds);
   endtask

   task automatic end_xfer(input int max_cycles);
      int n = 0;
      while (exp_addr_q.size() != 0 && n < max_cycles) begin
         tick();
         n++;
      end
      chk("xfer_remaining", exp_addr_q.size(), 0);
      chk("end_busy", busy_o, 1'b0);
   endtask

   initial begin
      int base;
      int n;
      resetn_i = 1'b0;
      rx_ch_ready_i = 1'b1;
      cmd_start_i = 1'b0;
      cmd_clr_i = 1'b0;
      cfg_start_addr_i = '0;
      cfg_datasize_i = '0;
      cfg_mode_i = '0;
      cfg_len0_i = '0;
      cfg_len1_i = '0;
      cfg_stride_i = '0;
      stream_data_i = '0;
      stream_valid_i = 1'b0;

      #3;
      chk("rst_addr", rx_ch_addr_o, 0);
      chk("rst_ds", rx_ch_datasize_o, 0);
      chk("rst_valid", rx_ch_valid_o, 0);
      chk("rst_done", cmd_done_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_sready", stream_ready_o, 1);
      chk("rst_data", rx_ch_data_o, 0);
      @(negedge clk_i);
      @(negedge clk_i);
      resetn_i = 1'b1;
      tick();

      // Linear, then back-to-back starts in the done-pulse cycle.
      push_words(4);
      start_xfer(15'h100, 2'b10, 2'd0, 3, 0, '0);
      end_xfer(50);
      push_words(6);
      start_xfer(15'h000, 2'b00, 2'd1, 2, 1, '0);
      end_xfer(50);
      push_words(6);
      start_xfer(15'h020, 2'b01, 2'd2, 1, 2, '0);
      end_xfer(50);
      push_words(4);
      start_xfer(15'h040, 2'b10, 2'd3, 1, 1, 15'h010);
      end_xfer(50);
      push_words(6);
      start_xfer(15'h7FF0, 2'b10, 2'd3, 1, 2, 15'h020);
      end_xfer(50);
      tick();

      // Backpressure: overfill the FIFO in IDLE, then drain with random ready.
      push_words(8);
      for (int i = 0; i < 6; i++) tick();
      chk("bp_full_sready", stream_ready_o, 1'b0);
      rand_rdy = 1'b1;
      start_xfer(15'h200, 2'b10, 2'd0, 7, 0, '0);
      end_xfer(400);
      rand_rdy = 1'b0;
      rx_ch_ready_i = 1'b1;
      tick();

      // Abort after two beats, colliding with a start request.
      push_words(8);
      start_xfer(15'h300, 2'b10, 2'd0, 7, 0, '0);
      base = accepts;
      n = 0;
      while (accepts < base + 2 && n < 50) begin
         tick();
         n++;
      end
      chk("abort_two_beats", accepts - base, 2);
      rx_ch_ready_i = 1'b0;
      cmd_clr_i = 1'b1;
      cmd_start_i = 1'b1;
      cfg_start_addr_i = 15'h555;
      tick();
      cmd_clr_i = 1'b0;
      cmd_start_i = 1'b0;
      rx_ch_ready_i = 1'b1;
      stim_q.delete();
      exp_addr_q.delete();
      exp_data_q.delete();
      chk("abort_busy", busy_o, 1'b0);
      chk("abort_valid", rx_ch_valid_o, 1'b0);
      chk("abort_empty", stream_ready_o, 1'b1);
      for (int i = 0; i < 3; i++) tick();

      push_words(4);
      start_xfer(15'h010, 2'b00, 2'd1, 1, 1, '0);
      end_xfer(50);
      tick();

      // Asynchronous reset in the middle of a transfer.
      push_words(4);
      start_xfer(15'h400, 2'b10, 2'd0, 3, 0, '0);
      tick();
      tick();
      #2;
      resetn_i = 1'b0;
      #1;
      chk("mrst_addr", rx_ch_addr_o, 0);
      chk("mrst_busy", busy_o, 0);
      chk("mrst_valid", rx_ch_valid_o, 0);
      chk("mrst_ds", rx_ch_datasize_o, 0);
      chk("mrst_sready", stream_ready_o, 1);
      chk("mrst_data", rx_ch_data_o, 0);
      @(negedge clk_i);
      resetn_i = 1'b1;
      stim_q.delete();
      exp_addr_q.delete();
      exp_data_q.delete();
      fifo_cnt = 0;
      busy_exp = 1'b0;
      done_exp = 1'b0;
      stall_prev = 1'b0;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
